// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared state encoding and register/WB constants for the hazard controller
package pipe_ctrl_pkg;
    typedef enum logic [1:0] {RUN, MWAIT, FAULT} state_e;
    localparam int REG_AW = 5;
    localparam logic [REG_AW-1:0] REG_ZERO = '0;
    localparam logic [1:0] WB_BUBBLE = 2'b00;
endpackage

// File: rtl/hazard_detect.sv
// hazard_detect: combinational load-use compare between the load in EX and the instruction in ID
module hazard_detect
    import pipe_ctrl_pkg::*;
#(
    parameter int W = REG_AW
) (
    input  logic         ex_memread_i,
    input  logic [W-1:0] ex_rt_i,
    input  logic [W-1:0] id_rs_i,
    input  logic [W-1:0] id_rt_i,
    input  logic         id_uses_rt_i,
    output logic         lu_o
);
    // register 0 is hardwired, so a load into it never creates a dependency
    assign lu_o = ex_memread_i & (ex_rt_i != W'(REG_ZERO)) &
                  ((ex_rt_i == id_rs_i) | (id_uses_rt_i & (ex_rt_i == id_rt_i)));
endmodule

// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: stall/flush/freeze controller for the 5-stage pipeline (optional STALL_PERF_EN perf counters)
module pipe_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int REG_AW      = 5,
    parameter int TO_W        = 8,
    parameter int MEM_TIMEOUT = 200,
    parameter int PERF_W      = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [REG_AW-1:0] id_rs_i,
    input  logic [REG_AW-1:0] id_rt_i,
    input  logic              id_uses_rt_i,
    input  logic              ex_memread_i,
    input  logic [REG_AW-1:0] ex_rt_i,
    input  logic              id_branch_taken_i,
    input  logic              mem_req_i,
    input  logic              dmem_ack_i,
    output logic              dmem_req_o,
    output logic              pc_write_o,
    output logic              ifid_write_o,
    output logic              ifid_flush_o,
    output logic              idex_write_o,
    output logic              idex_bubble_o,
    output logic              exmem_write_o,
    output logic              memwb_bubble_o,
    output logic              fault_o,
    output logic [PERF_W-1:0] perf_lu_cnt_o,
    output logic [PERF_W-1:0] perf_mem_cnt_o
);
    state_e            state_q, state_d;
    logic [TO_W-1:0]   wait_q, wait_d;
    logic              fault_q;
    logic              lu, active, mem_stall;

    hazard_detect #(.W(REG_AW)) u_hd (
        .ex_memread_i (ex_memread_i),
        .ex_rt_i      (ex_rt_i),
        .id_rs_i      (id_rs_i),
        .id_rt_i      (id_rt_i),
        .id_uses_rt_i (id_uses_rt_i),
        .lu_o         (lu)
    );

    assign active    = state_q != FAULT;
    assign mem_stall = active & mem_req_i & ~dmem_ack_i;
    assign fault_o   = fault_q;

    // next state: count wait cycles of an outstanding access, trap into FAULT on timeout
    always_comb begin
        state_d = state_q;
        wait_d  = wait_q;
        if (state_q == RUN && mem_stall) begin
            state_d = MWAIT;
            wait_d  = TO_W'(1);
        end else if (state_q == MWAIT) begin
            if (mem_stall) begin
                wait_d  = wait_q + 1'b1;
                state_d = (wait_d == TO_W'(MEM_TIMEOUT)) ? FAULT : MWAIT;
            end else begin
                state_d = RUN;
                wait_d  = '0;
            end
        end
    end

    // state, wait counter and sticky fault registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= RUN;
            wait_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            fault_q <= fault_q | (state_d == FAULT);
        end
    end

    // pipeline controls in priority order: reset, fault, memory freeze, load-use bubble, branch flush
    always_comb begin
        dmem_req_o     = mem_req_i & active;
        pc_write_o     = 1'b1;
        ifid_write_o   = 1'b1;
        idex_write_o   = 1'b1;
        exmem_write_o  = 1'b1;
        idex_bubble_o  = 1'b0;
        memwb_bubble_o = 1'b0;
        ifid_flush_o   = 1'b0;
        if (rst_i || !active || mem_stall) begin
            pc_write_o     = 1'b0;
            ifid_write_o   = 1'b0;
            idex_write_o   = 1'b0;
            exmem_write_o  = 1'b0;
            memwb_bubble_o = 1'b1;
            idex_bubble_o  = rst_i | ~active;
            dmem_req_o     = mem_req_i & active & ~rst_i;
        end else if (lu) begin
            pc_write_o    = 1'b0;
            ifid_write_o  = 1'b0;
            idex_bubble_o = 1'b1;
        end else begin
            ifid_flush_o = id_branch_taken_i;
        end
    end

`ifdef STALL_PERF_EN
    logic [PERF_W-1:0] lu_cnt_q, mem_cnt_q;
    logic              lu_eff;

    assign lu_eff         = lu & ~mem_stall & active;
    assign perf_lu_cnt_o  = lu_cnt_q;
    assign perf_mem_cnt_o = mem_cnt_q;

    // saturating stall-cycle counters
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            lu_cnt_q  <= '0;
            mem_cnt_q <= '0;
        end else begin
            if (lu_eff && !(&lu_cnt_q)) lu_cnt_q <= lu_cnt_q + 1'b1;
            if (mem_stall && !(&mem_cnt_q)) mem_cnt_q <= mem_cnt_q + 1'b1;
        end
    end
`else
    assign perf_lu_cnt_o  = '0;
    assign perf_mem_cnt_o = '0;
`endif
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: scoreboard bench driving directed and random traffic against a cycle-level model
module tb_pipe_hazard_ctrl;
    localparam int TIMEOUT = 200;

    typedef struct packed {
        logic [8:0]  ctl;
        logic [15:0] lu;
        logic [15:0] mem;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [4:0] rs = '0, rt = '0, ert = '0;
    logic uses = 1'b0, mrd = 1'b0, br = 1'b0, mreq = 1'b0, ack = 1'b0;
    logic dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, fault;
    logic [15:0] plu, pmem;

    exp_t q[$];
    int n_cmp = 0;
    int n_bad = 0;

    int waited = 0;
    bit faulted = 0;
    int lu_cnt = 0;
    int mem_cnt = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .id_rs_i           (rs),
        .id_rt_i           (rt),
        .id_uses_rt_i      (uses),
        .ex_memread_i      (mrd),
        .ex_rt_i           (ert),
        .id_branch_taken_i (br),
        .mem_req_i         (mreq),
        .dmem_ack_i        (ack),
        .dmem_req_o        (dmem_req),
        .pc_write_o        (pc_w),
        .ifid_write_o      (ifid_w),
        .ifid_flush_o      (ifid_f),
        .idex_write_o      (idex_w),
        .idex_bubble_o     (idex_b),
        .exmem_write_o     (exmem_w),
        .memwb_bubble_o    (memwb_b),
        .fault_o           (fault),
        .perf_lu_cnt_o     (plu),
        .perf_mem_cnt_o    (pmem)
    );

    // one cycle: apply inputs, push the expected response, then advance the model past the edge
    task automatic cyc(input bit r, input bit m, input bit a, input bit b, input bit ld,
                       input logic [4:0] e, input logic [4:0] s, input logic [4:0] t, input bit u);
        exp_t x;
        bit hz, ms;
        bit [8:0] c;
        @(posedge clk);
        #1;
        rst = r; mreq = m; ack = a; br = b; mrd = ld; ert = e; rs = s; rt = t; uses = u;
        hz = ld && e != 0 && (e == s || (u && e == t));
        ms = !faulted && m && !a;
        // ctl = {dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, fault}
        if (r)            c = {1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, faulted};
        else if (faulted) c = 9'b0_0000_1011;
        else if (ms)      c = 9'b1_0000_0010;
        else if (hz)      c = {m, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        else              c = {m, 1'b1, 1'b1, b, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
        x.ctl = c;
`ifdef STALL_PERF_EN
        x.lu  = 16'(lu_cnt);
        x.mem = 16'(mem_cnt);
`else
        x.lu  = '0;
        x.mem = '0;
`endif
        q.push_back(x);
        if (r) begin
            waited = 0; faulted = 0; lu_cnt = 0; mem_cnt = 0;
        end else if (!faulted) begin
            if (ms) begin
                waited++;
                if (mem_cnt < 65535) mem_cnt++;
                if (waited == TIMEOUT) faulted = 1;
            end else begin
                waited = 0;
                if (hz && lu_cnt < 65535) lu_cnt++;
            end
        end
    endtask

    task automatic idle();
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
    endtask

    // monitor: every cycle the DUT presents its controls, compare against the oldest expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t e;
            e = q.pop_front();
            n_cmp++;
            if ({dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, fault} !== e.ctl) begin
                n_bad++;
                $display("FAIL ctl t=%0t got=%b want=%b", $time,
                         {dmem_req, pc_w, ifid_w, ifid_f, idex_w, idex_b, exmem_w, memwb_b, fault}, e.ctl);
            end
            n_cmp++;
            if (plu !== e.lu) begin
                n_bad++;
                $display("FAIL perf_lu t=%0t got=%0d want=%0d", $time, plu, e.lu);
            end
            n_cmp++;
            if (pmem !== e.mem) begin
                n_bad++;
                $display("FAIL perf_mem t=%0t got=%0d want=%0d", $time, pmem, e.mem);
            end
        end
    end

    initial begin
        logic [4:0] pool [4];
        pool = '{5'd0, 5'd8, 5'd9, 5'd3};
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 1, 1, 8, 8, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 1, 8, 8, 0, 0);
        idle();
        cyc(0, 0, 0, 0, 1, 0, 0, 0, 1);
        cyc(0, 0, 0, 0, 1, 9, 3, 9, 0);
        cyc(0, 0, 0, 0, 1, 9, 3, 9, 1);
        idle();
        cyc(0, 0, 0, 1, 0, 0, 3, 9, 1);
        cyc(0, 0, 0, 1, 1, 3, 3, 9, 1);
        cyc(0, 0, 0, 1, 0, 3, 3, 9, 1);
        repeat (3) cyc(0, 1, 0, 1, 1, 8, 8, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 0, 0, 0, 0, 0);
        repeat (2) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (TIMEOUT + 4) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 1, 1, 8, 8, 0, 0);
        repeat (3) idle();
        cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (5) cyc(0, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(1, 1, 0, 0, 0, 0, 0, 0, 0);
        cyc(0, 1, 1, 0, 0, 0, 0, 0, 0);
        idle();
        repeat (2000) begin
            cyc($urandom_range(0, 299) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 3) == 0, $urandom_range(0, 1) == 1,
                pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)], pool[$urandom_range(0, 3)],
                $urandom_range(0, 1) == 1);
        end
        repeat (TIMEOUT - 1) cyc(0, 1, 0, 0, 1, 8, 8, 0, 0);
        cyc(0, 1, 0, 0, 1, 8, 8, 0, 0);
        repeat (3) cyc(0, 0, 0, 1, 0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        if (q.size() != 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL drain left=%0d want=0", q.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
